// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//
// Drives a multiplexed 7-segment display through one shared external
// BCD-to-7-segment decoder. Each digit is lit for REFRESH_DIV cycles, then
// every digit is switched off for BLANK_CYCLES guard cycles to avoid ghosting.
// A new display value is taken through a valid/ready load port. It is held
// as pending and becomes visible only at a frame boundary, or when scanning
// starts, so the display never changes mid-frame.
//
// Optional build macro:
//   DISPLAY_SCAN_LZB_EN - leading-zero blanking. A digit whose nibble and all
//                         more-significant nibbles are zero stays dark during
//                         its slot. Digit 0 is never blanked.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable      1 = scan, 0 = display off (returns to IDLE)
//   load_valid  new value offered on load_value
//   load_ready  no value pending; a load can be taken
//   load_value  BCD nibbles, [3:0] = digit 0
//   bcd_out     nibble of the current digit, to the shared decoder
//   seg_in      decoder result, active-high {G..A}
//   seg_out     registered segments to pins, active-high
//   digit_sel   registered one-hot digit select, active-high
//   frame_done  registered one-cycle pulse at each frame boundary

module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RD_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pending_value;
    logic                    pending;
    logic                    commit;
    logic                    wrap;
    logic                    advance;
    logic                    accept;
    logic                    blank_digit;
    logic                    lit;

    // Load handshake: a value transfers on a rising edge where
    // load_valid && load_ready. load_ready is simply !pending, so it never
    // depends on load_valid. A commit and an accept can never coincide,
    // because a commit needs pending=1 and an accept needs pending=0. A load
    // taken on a boundary edge therefore waits for the next boundary.
    assign load_ready = !pending;
    assign accept     = load_valid && !pending;

    assign bcd_out = display[{idx, 2'b00} +: 4];

`ifdef DISPLAY_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  zero_above;

    // lead_zero[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (display[i*4 +: 4] == 4'd0);
            lead_zero[i] = zero_above;
        end
    end

    assign blank_digit = (idx != '0) && lead_zero[idx];
`else
    assign blank_digit = 1'b0;
`endif

    assign lit = (state == SHOW) && !blank_digit;

    // Next-state logic. The digit advances after the guard, or directly from
    // SHOW when there are no guard cycles. Wrapping past the last digit marks
    // the frame boundary: frame_done and any pending commit share that edge.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        commit  = 1'b0;
        wrap    = 1'b0;
        advance = 1'b0;

        if (!enable) begin
            state_n = IDLE;
            idx_n   = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    commit  = pending;
                    idx_n   = '0;
                    cnt_n   = '0;
                    state_n = SHOW;
                end
                SHOW: begin
                    if (cnt == RD_LAST) begin
                        cnt_n = '0;
                        if (BLANK_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_n = GUARD;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == BL_LAST) begin
                        cnt_n   = '0;
                        advance = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end
            endcase

            if (advance) begin
                state_n = SHOW;
                if (idx == IDX_LAST) begin
                    idx_n  = '0;
                    wrap   = 1'b1;
                    commit = pending;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            cnt           <= '0;
            display       <= '0;
            pending_value <= '0;
            pending       <= 1'b0;
            seg_out       <= '0;
            digit_sel     <= '0;
            frame_done    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            frame_done <= wrap;

            if (commit) begin
                display <= pending_value;
                pending <= 1'b0;
            end else if (accept) begin
                pending_value <= load_value;
                pending       <= 1'b1;
            end

            // Pins follow the internal state one cycle later, and both
            // outputs always change on the same edge.
            seg_out   <= lit ? seg_in : '0;
            digit_sel <= lit ? (NUM_DIGITS'(1) << idx) : '0;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with NUM_DIGITS=2, REFRESH_DIV=4,
// BLANK_CYCLES=2 (12-cycle frame). The bench acts as the external 7-segment
// decoder. Window position p is the p-th edge after a frame starts, so
// positions 0..3 light digit 0, 4..5 are guard, 6..9 light digit 1,
// 10..11 are guard, and frame_done rises on position 11.

module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_value = 8'h00;
    logic [3:0] bcd_out;
    logic [6:0] seg_in;
    logic [6:0] seg_out;
    logic [1:0] digit_sel;
    logic       frame_done;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    display_scan_ctrl #(
        .NUM_DIGITS  (2),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .bcd_out   (bcd_out),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    // External decoder, active-high {G..A}; nibbles above 9 are blank.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: seg_of = 7'h3F;
            4'd1: seg_of = 7'h06;
            4'd2: seg_of = 7'h5B;
            4'd3: seg_of = 7'h4F;
            4'd4: seg_of = 7'h66;
            4'd5: seg_of = 7'h6D;
            4'd6: seg_of = 7'h7D;
            4'd7: seg_of = 7'h07;
            4'd8: seg_of = 7'h7F;
            4'd9: seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    assign seg_in = seg_of(bcd_out);

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check(input int pos, input logic [7:0] disp);
        logic [1:0] exp_sel;
        logic [3:0] nib;
        step();
        if (pos < 4)       exp_sel = 2'b01;
        else if (pos < 6)  exp_sel = 2'b00;
        else if (pos < 10) exp_sel = 2'b10;
        else               exp_sel = 2'b00;
        nib = exp_sel[1] ? disp[7:4] : disp[3:0];
`ifdef DISPLAY_SCAN_LZB_EN
        if (exp_sel == 2'b10 && disp[7:4] == 4'd0) exp_sel = 2'b00;
`endif
        chk($sformatf("digit_sel p%0d", pos), digit_sel, exp_sel);
        chk($sformatf("seg_out p%0d", pos), seg_out, (exp_sel != 2'b00) ? seg_of(nib) : 7'h00);
        if (exp_sel != 2'b00) chk($sformatf("bcd_out p%0d", pos), bcd_out, nib);
        chk($sformatf("frame_done p%0d", pos), frame_done, pos == 11);
    endtask

    // Runs positions 0..last_pos of a window showing disp. When load_pos
    // is a valid position, val is offered for that one edge only.
    task automatic window_load(input logic [7:0] disp, input int last_pos,
                               input int load_pos, input logic [7:0] val);
        for (int p = 0; p <= last_pos; p++) begin
            if (p == load_pos) begin
                load_valid = 1'b1;
                load_value = val;
            end
            tick_check(p, disp);
            if (p == load_pos) begin
                chk("load_ready after accept", load_ready, 1'b0);
                load_valid = 1'b0;
            end
        end
    endtask

    task automatic run_window(input logic [7:0] disp);
        window_load(disp, 11, -1, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values while rst_n is low
        #3;
        chk("reset digit_sel", digit_sel, 2'b00);
        chk("reset seg_out", seg_out, 7'h00);
        chk("reset frame_done", frame_done, 1'b0);
        chk("reset bcd_out", bcd_out, 4'h0);
        #9 rst_n = 1'b1;
        #1;
        chk("load_ready after release", load_ready, 1'b1);
        step();
        step();
        chk("idle digit_sel", digit_sel, 2'b00);

        // 1: plain scan of 00
        enable = 1'b1;
        step();
        chk("start digit_sel", digit_sel, 2'b00);
        chk("start frame_done", frame_done, 1'b0);
        run_window(8'h00);

        // 2: load 15 at position 3, visible from the next frame
        window_load(8'h00, 11, 3, 8'h15);
        chk("load_ready after commit 15", load_ready, 1'b1);

        // 3: valid held with 42 then 37; only 42 is taken first
        load_valid = 1'b1;
        load_value = 8'h42;
        for (int p = 0; p < 12; p++) begin
            tick_check(p, 8'h15);
            if (p == 0) begin
                chk("load_ready 42 pending", load_ready, 1'b0);
                load_value = 8'h37;
            end
        end
        chk("load_ready at boundary 42", load_ready, 1'b1);
        for (int p = 0; p < 12; p++) begin
            tick_check(p, 8'h42);
            if (p == 0) begin
                chk("load_ready 37 pending", load_ready, 1'b0);
                load_valid = 1'b0;
            end
        end
        run_window(8'h37);

        // 4: load 96, then drop enable mid-SHOW of digit 1
        window_load(8'h37, 7, 2, 8'h96);
        enable = 1'b0;
        step();
        step();
        chk("disabled digit_sel", digit_sel, 2'b00);
        chk("disabled seg_out", seg_out, 7'h00);
        chk("disabled frame_done", frame_done, 1'b0);
        chk("disabled pending kept", load_ready, 1'b0);
        step();
        step();
        step();
        chk("disabled digit_sel later", digit_sel, 2'b00);
        enable = 1'b1;
        step();
        chk("reenable digit_sel", digit_sel, 2'b00);
        chk("reenable bcd_out", bcd_out, 4'h6);
        chk("reenable load_ready", load_ready, 1'b1);
        run_window(8'h96);

        // 5: load 58, then reset mid-GUARD; 58 must never appear
        window_load(8'h96, 3, 1, 8'h58);
        step();
        rst_n = 1'b0;
        #2;
        chk("async reset digit_sel", digit_sel, 2'b00);
        chk("async reset seg_out", seg_out, 7'h00);
        chk("async reset load_ready", load_ready, 1'b1);
        chk("async reset bcd_out", bcd_out, 4'h0);
        step();
        #2 rst_n = 1'b1;
        step();
        chk("post reset digit_sel", digit_sel, 2'b00);
        chk("post reset frame_done", frame_done, 1'b0);
        run_window(8'h00);

        // 6: leading-zero cases and a non-BCD nibble passed through blank
        window_load(8'h00, 11, 0, 8'h07);
        window_load(8'h07, 11, 0, 8'hC0);
        window_load(8'hC0, 11, 0, 8'h00);
        run_window(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
